id_queue_stage: RTL and testbench

- Pipelined successor to the single-cycle instruction decoder.
- Takes fetched {pc, inst} pairs through a valid/ready handshake and decodes RV32I plus Zicsr/mret entirely internally (no external opcode one-hot).
- Buffers decoded control bundles in a DEPTH-entry FIFO and presents the head bundle to the execute stage.
- Supports pipeline flush and backpressure. All control outputs use the codebase's active-low encodings.

---
 rtl/id_queue_stage.sv | 256 +++++++++++++++++++++++++
 tb/tb_id_queue_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_queue_stage.sv
// id_queue_stage: RV32I + Zicsr/mret decoder feeding a DEPTH-entry queue of decoded control bundles.
// Define ID_RVM_EN to decode RV32M on OP/funct7=0000001 and expose the mdu_funct port.
module id_queue_stage #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
`ifdef ID_RVM_EN
  output logic [2:0]       mdu_funct,
`endif
  output logic             alu_src_1,
  output logic             alu_src_2,
  output logic [31:0]      alu_imm_1,
  output logic [31:0]      alu_imm_2,
  output logic [7:0]       alu_op,
  output logic [7:0]       mem_op,
  output logic [7:0]       csr_op,
  output logic             gpr_we,
  output logic             load,
  output logic             store,
  output logic             illegal,
  output logic [PTR_W:0]   count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        src_1;
    logic        src_2;
    logic [31:0] imm_1;
    logic [31:0] imm_2;
    logic [7:0]  alu_op;
    logic [7:0]  mem_op;
    logic [7:0]  csr_op;
    logic        gpr_we;
    logic        load;
    logic        store;
    logic        illegal;
`ifdef ID_RVM_EN
    logic [2:0]  mdu_funct;
`endif
  } bundle_t;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  function automatic bundle_t idle_bundle();
    bundle_t b;
    b        = '0;
    b.src_1  = 1'b1;
    b.src_2  = 1'b1;
    b.alu_op = 8'hFB;
    b.mem_op = 8'hFF;
    b.csr_op = 8'hFF;
    b.gpr_we = 1'b1;
    b.load   = 1'b1;
    b.store  = 1'b1;
    return b;
  endfunction

  // alt is inst[30]; SUB only exists on register-register OP
  function automatic logic [7:0] alu_code(input logic [2:0] f3, input logic alt, input logic is_op);
    logic [7:0] code;
    case (f3)
      3'b000:  code = (alt && is_op) ? 8'hFA : 8'hFB;
      3'b001:  code = 8'hD8;
      3'b010:  code = 8'h7A;
      3'b011:  code = 8'hBA;
      3'b100:  code = 8'hFC;
      3'b101:  code = alt ? 8'hF0 : 8'hE8;
      3'b110:  code = 8'hFD;
      default: code = 8'hFE;
    endcase
    return code;
  endfunction

  function automatic bundle_t decode(input logic [31:0] pc, input logic [31:0] inst);
    bundle_t           b;
    logic [2:0]        f3;
    logic signed [31:0] imm_i, imm_s, imm_u;
    logic              wr, bad;
    b     = idle_bundle();
    f3    = inst[14:12];
    imm_i = {{20{inst[31]}}, inst[31:20]};
    imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    imm_u = {inst[31:12], 12'h000};
    wr    = 1'b0;
    bad   = (inst[1:0] != 2'b11);
    b.pc    = pc;
    b.rd    = inst[11:7];
    b.rs1   = inst[19:15];
    b.rs2   = inst[24:20];
    b.imm_2 = imm_i;
    case (inst[6:2])
      OPC_LUI:   begin b.imm_2 = imm_u; wr = 1'b1; end
      OPC_AUIPC: begin b.imm_1 = pc; b.imm_2 = imm_u; wr = 1'b1; end
      OPC_JAL, OPC_JALR: begin b.imm_1 = pc; b.imm_2 = 32'd4; wr = 1'b1; end
      OPC_BRANCH: begin b.alu_op = 8'hFA; b.src_1 = 1'b0; b.src_2 = 1'b0; end
      OPC_LOAD: begin
        b.src_1 = 1'b0;
        b.load  = 1'b0;
        wr      = 1'b1;
        case (f3)
          3'b000:  b.mem_op[7] = 1'b0;
          3'b001:  b.mem_op[6] = 1'b0;
          3'b010:  b.mem_op[5] = 1'b0;
          3'b100:  b.mem_op[4] = 1'b0;
          3'b101:  b.mem_op[3] = 1'b0;
          default: bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        b.src_1 = 1'b0;
        b.store = 1'b0;
        b.imm_2 = imm_s;
        case (f3)
          3'b000:  b.mem_op[2] = 1'b0;
          3'b001:  b.mem_op[1] = 1'b0;
          3'b010:  b.mem_op[0] = 1'b0;
          default: bad = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin b.src_1 = 1'b0; b.alu_op = alu_code(f3, inst[30], 1'b0); wr = 1'b1; end
      OPC_OP: begin
        b.src_1 = 1'b0;
        b.src_2 = 1'b0;
        wr      = 1'b1;
        if (inst[31:25] == 7'b0000001) begin
`ifdef ID_RVM_EN
          b.alu_op    = 8'hFF;
          b.mdu_funct = f3;
`else
          bad = 1'b1;
`endif
        end else begin
          b.alu_op = alu_code(f3, inst[30], 1'b1);
        end
      end
      OPC_SYSTEM: begin
        b.csr_op[1] = ~inst[14];
        case (f3[1:0])
          2'b00: begin
            if (f3[2]) bad = 1'b1;
            else begin
              case (inst[22:20])
                3'b000:  b.csr_op[7] = 1'b0;
                3'b001:  b.csr_op[6] = 1'b0;
                3'b010:  b.csr_op[5] = 1'b0;
                default: bad = 1'b1;
              endcase
            end
          end
          2'b01:   begin b.csr_op[4] = 1'b0; wr = 1'b1; end
          2'b10:   begin b.csr_op[3] = 1'b0; wr = 1'b1; end
          default: begin b.csr_op[2] = 1'b0; wr = 1'b1; end
        endcase
      end
      default: bad = 1'b1;
    endcase
    if (wr && (inst[11:7] != 5'd0)) b.gpr_we = 1'b0;
    if (bad) begin
      b         = idle_bundle();
      b.pc      = pc;
      b.illegal = 1'b1;
    end
    return b;
  endfunction

  // Stage p0: decode the offered instruction and qualify push/pop
  bundle_t          dec_p0;
  logic             push_p0, pop_p0;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  assign dec_p0    = decode(in_pc, in_inst);
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push_p0   = in_valid & in_ready & ~flush;
  assign pop_p0    = out_valid & out_ready & ~flush;

  // Stage p1: queued bundles; storage carries no reset
  bundle_t mem_p1 [DEPTH];
  bundle_t head_p1;

  always_ff @(posedge clk) begin
    if (push_p0) mem_p1[wr_ptr] <= dec_p0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_p0) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_p0)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_p0, pop_p0})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    head_p1 = idle_bundle();
    if (out_valid) head_p1 = mem_p1[rd_ptr];
  end

  assign out_pc    = head_p1.pc;
  assign out_rd    = head_p1.rd;
  assign out_rs1   = head_p1.rs1;
  assign out_rs2   = head_p1.rs2;
  assign alu_src_1 = head_p1.src_1;
  assign alu_src_2 = head_p1.src_2;
  assign alu_imm_1 = head_p1.imm_1;
  assign alu_imm_2 = head_p1.imm_2;
  assign alu_op    = head_p1.alu_op;
  assign mem_op    = head_p1.mem_op;
  assign csr_op    = head_p1.csr_op;
  assign gpr_we    = head_p1.gpr_we;
  assign load      = head_p1.load;
  assign store     = head_p1.store;
  assign illegal   = head_p1.illegal;
`ifdef ID_RVM_EN
  assign mdu_funct = head_p1.mdu_funct;
`endif

endmodule

// File: tb/tb_id_queue_stage.sv
// Bench for id_queue_stage: queue-based reference model compared every cycle, plus literal spot checks.
module tb_id_queue_stage;
  localparam int DEPTH = 2;
  localparam int PTR_W = 1;

  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, out_pc, alu_imm_1, alu_imm_2;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic        alu_src_1, alu_src_2, gpr_we, load, store, illegal;
  logic [7:0]  alu_op, mem_op, csr_op;
  logic [PTR_W:0] count;

  id_queue_stage #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .alu_src_1(alu_src_1), .alu_src_2(alu_src_2),
    .alu_imm_1(alu_imm_1), .alu_imm_2(alu_imm_2), .alu_op(alu_op),
    .mem_op(mem_op), .csr_op(csr_op), .gpr_we(gpr_we), .load(load),
    .store(store), .illegal(illegal), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic        s1, s2;
    logic [31:0] i1, i2;
    logic [7:0]  aop, mop, cop;
    logic        we, ld, st, ill;
  } exp_t;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e.pc = 0; e.rd = 0; e.rs1 = 0; e.rs2 = 0;
    e.s1 = 1; e.s2 = 1; e.i1 = 0; e.i2 = 0;
    e.aop = 8'hFB; e.mop = 8'hFF; e.cop = 8'hFF;
    e.we = 1; e.ld = 1; e.st = 1; e.ill = 0;
    return e;
  endfunction

  // Reference decode: classify by opcode, then look outputs up in per-funct3 tables.
  function automatic exp_t ref_decode(input logic [31:0] pc, input logic [31:0] w);
    exp_t e;
    logic [31:0] imm_i, imm_s, imm_u;
    logic [2:0]  f3;
    logic        ok, writes;
    logic [7:0]  alu_tab [8];
    int          ld_bit [8];
    e = idle_exp();
    alu_tab = '{8'hFB, 8'hD8, 8'h7A, 8'hBA, 8'hFC, 8'hE8, 8'hFD, 8'hFE};
    ld_bit  = '{7, 6, 5, -1, 4, 3, -1, -1};
    f3     = w[14:12];
    imm_i  = 32'($signed(w) >>> 20);
    imm_s  = (imm_i & ~32'h1F) | {27'd0, w[11:7]};
    imm_u  = w & 32'hFFFF_F000;
    ok     = (w[1:0] == 2'b11);
    writes = 0;
    e.pc = pc; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.i2 = imm_i;
    case (w[6:2])
      5'b01101: begin e.i2 = imm_u; writes = 1; end
      5'b00101: begin e.i1 = pc; e.i2 = imm_u; writes = 1; end
      5'b11011, 5'b11001: begin e.i1 = pc; e.i2 = 4; writes = 1; end
      5'b11000: begin e.aop = 8'hFA; e.s1 = 0; e.s2 = 0; end
      5'b00000: begin
        e.s1 = 0; writes = 1;
        if (ld_bit[f3] < 0) ok = 0;
        else begin e.mop[ld_bit[f3]] = 0; e.ld = 0; end
      end
      5'b01000: begin
        e.s1 = 0; e.i2 = imm_s;
        if (f3 > 3'd2) ok = 0;
        else begin e.mop[2 - f3] = 0; e.st = 0; end
      end
      5'b00100: begin
        e.s1 = 0; writes = 1; e.aop = alu_tab[f3];
        if (f3 == 3'd5 && w[30]) e.aop = 8'hF0;
      end
      5'b01100: begin
        e.s1 = 0; e.s2 = 0; writes = 1;
        if (w[31:25] == 7'b0000001) ok = 0;
        else begin
          e.aop = alu_tab[f3];
          if (w[30] && f3 == 3'd0) e.aop = 8'hFA;
          if (w[30] && f3 == 3'd5) e.aop = 8'hF0;
        end
      end
      5'b11100: begin
        if (f3 == 3'd0) begin
          case (w[22:20])
            3'd0:    e.cop[7] = 0;
            3'd1:    e.cop[6] = 0;
            3'd2:    e.cop[5] = 0;
            default: ok = 0;
          endcase
        end else if (f3 == 3'd4) ok = 0;
        else begin
          e.cop[5 - f3[1:0]] = 0;
          if (w[14]) e.cop[1] = 0;
          writes = 1;
        end
      end
      default: ok = 0;
    endcase
    if (writes && e.rd != 0) e.we = 0;
    if (!ok) begin e = idle_exp(); e.pc = pc; e.ill = 1; end
    return e;
  endfunction

  // Model queue follows the handshake rules on every edge
  always @(posedge clk or negedge rst) begin
    if (!rst) exp_q.delete();
    else if (flush) exp_q.delete();
    else begin
      automatic bit do_pop  = (exp_q.size() > 0) && out_ready;
      automatic bit do_push = in_valid && (exp_q.size() < DEPTH);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(ref_decode(in_pc, in_inst));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      automatic exp_t e = (exp_q.size() > 0) ? exp_q[0] : idle_exp();
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
      chk("in_ready",  {31'd0, in_ready},  {31'd0, exp_q.size() < DEPTH});
      chk("count",     32'(count),         32'(exp_q.size()));
      chk("out_pc",    out_pc,    e.pc);
      chk("out_rd",    32'(out_rd),  32'(e.rd));
      chk("out_rs1",   32'(out_rs1), 32'(e.rs1));
      chk("out_rs2",   32'(out_rs2), 32'(e.rs2));
      chk("alu_src_1", 32'(alu_src_1), 32'(e.s1));
      chk("alu_src_2", 32'(alu_src_2), 32'(e.s2));
      chk("alu_imm_1", alu_imm_1, e.i1);
      chk("alu_imm_2", alu_imm_2, e.i2);
      chk("alu_op",    32'(alu_op), 32'(e.aop));
      chk("mem_op",    32'(mem_op), 32'(e.mop));
      chk("csr_op",    32'(csr_op), 32'(e.cop));
      chk("gpr_we",    32'(gpr_we),  32'(e.we));
      chk("load",      32'(load),    32'(e.ld));
      chk("store",     32'(store),   32'(e.st));
      chk("illegal",   32'(illegal), 32'(e.ill));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] inst);
    in_valid = 1'b1; in_pc = pc; in_inst = inst;
  endtask

  // {pc, inst, alu_op, mem_op, csr_op, gpr_we, illegal}, hand-decoded
  typedef struct {
    logic [31:0] pc, inst;
    logic [7:0]  aop, mop, cop;
    logic        we, ill;
  } vec_t;

  vec_t vecs [16] = '{
    '{32'h100, 32'h00500093, 8'hFB, 8'hFF, 8'hFF, 1'b0, 1'b0},  // addi x1,x0,5
    '{32'h104, 32'h00815183, 8'hFB, 8'hF7, 8'hFF, 1'b0, 1'b0},  // lhu x3,8(x2)
    '{32'h108, 32'h00813183, 8'hFB, 8'hFF, 8'hFF, 1'b1, 1'b1},  // load funct3=011
    '{32'h10C, 32'h00000013, 8'hFB, 8'hFF, 8'hFF, 1'b1, 1'b0},  // addi x0,x0,0
    '{32'h110, 32'h00512623, 8'hFB, 8'hFE, 8'hFF, 1'b1, 1'b0},  // sw x5,12(x2)
    '{32'h114, 32'h40208233, 8'hFA, 8'hFF, 8'hFF, 1'b0, 1'b0},  // sub x4,x1,x2
    '{32'h118, 32'h4030D293, 8'hF0, 8'hFF, 8'hFF, 1'b0, 1'b0},  // srai x5,x1,3
    '{32'h11C, 32'h12345337, 8'hFB, 8'hFF, 8'hFF, 1'b0, 1'b0},  // lui x6,0x12345
    '{32'h120, 32'h00001397, 8'hFB, 8'hFF, 8'hFF, 1'b0, 1'b0},  // auipc x7,1
    '{32'h124, 32'h000000EF, 8'hFB, 8'hFF, 8'hFF, 1'b0, 1'b0},  // jal x1,0
    '{32'h128, 32'h00208463, 8'hFA, 8'hFF, 8'hFF, 1'b1, 1'b0},  // beq x1,x2,+8
    '{32'h12C, 32'h3002D473, 8'hFB, 8'hFF, 8'hED, 1'b0, 1'b0},  // csrrwi x8,mstatus,5
    '{32'h130, 32'h00000073, 8'hFB, 8'hFF, 8'h7F, 1'b1, 1'b0},  // ecall
    '{32'h134, 32'h30200073, 8'hFB, 8'hFF, 8'hDF, 1'b1, 1'b0},  // mret
    '{32'h138, 32'h023100B3, 8'hFB, 8'hFF, 8'hFF, 1'b1, 1'b1},  // mul (no M)
    '{32'h13C, 32'h00000001, 8'hFB, 8'hFF, 8'hFF, 1'b1, 1'b1}   // inst[1:0]!=11
  };

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; flush = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b0;
    chk_en = 1'b1;
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'hFB);

    // Decode table: push, spot-check, pop
    foreach (vecs[i]) begin
      out_ready = 1'b0;
      offer(vecs[i].pc, vecs[i].inst);
      cyc();
      in_valid = 1'b0;
      chk("vec_valid", 32'(out_valid), 32'd1);
      chk("vec_pc", out_pc, vecs[i].pc);
      chk("vec_alu_op", 32'(alu_op), 32'(vecs[i].aop));
      chk("vec_mem_op", 32'(mem_op), 32'(vecs[i].mop));
      chk("vec_csr_op", 32'(csr_op), 32'(vecs[i].cop));
      chk("vec_gpr_we", 32'(gpr_we), 32'(vecs[i].we));
      chk("vec_illegal", 32'(illegal), 32'(vecs[i].ill));
      if (i == 0) begin
        chk("addi_src1", 32'(alu_src_1), 32'd0);
        chk("addi_imm2", alu_imm_2, 32'd5);
      end
      if (i == 1) chk("lhu_load", 32'(load), 32'd0);
      if (i == 7) chk("lui_imm2", alu_imm_2, 32'h12345000);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
    end

    // Fill to DEPTH under backpressure, then a refused third push
    offer(32'h200, 32'h00100093); cyc();
    offer(32'h204, 32'h00200113); cyc();
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd2);
    offer(32'h208, 32'h00300193); cyc();
    chk("refused_count", 32'(count), 32'd2);
    chk("refused_head", out_pc, 32'h200);
    out_ready = 1'b1; cyc();
    chk("pop_ready", 32'(in_ready), 32'd1);
    chk("pop_order", out_pc, 32'h204);
    cyc();
    chk("pushpop_count", 32'(count), 32'd1);
    chk("pushpop_head", out_pc, 32'h208);
    offer(32'h20C, 32'h00400213); cyc();
    chk("wrap_count", 32'(count), 32'd1);
    chk("wrap_head", out_pc, 32'h20C);
    in_valid = 1'b0; cyc();
    out_ready = 1'b0;
    chk("drain_count", 32'(count), 32'd0);

    // Flush drops a queued entry and a concurrent push
    offer(32'h300, 32'h00500293); cyc();
    offer(32'h20, 32'h00512623); flush = 1'b1; out_ready = 1'b1; cyc();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    cyc();
    chk("flush_nostore", 32'(count), 32'd0);

    // Asynchronous reset with two entries queued
    offer(32'h400, 32'h00100093); cyc();
    offer(32'h404, 32'h00200113); cyc();
    in_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd2);
    rst = 1'b0;
    cyc();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_alu_op", 32'(alu_op), 32'hFB);
    rst = 1'b1;
    cyc();
    cyc();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
